gcbp_frame_ctrl: RTL and testbench
==================================

Name: gcbp_frame_ctrl

Overview:
- Frame-level sequencer for the GCBP line generator.
- Gates the generator's new-line strobe to the vertical sub-image window and writes each generated 128-bit GCBP line into a ping-pong sub-image BRAM.
- On frame completion, hands the filled bank to the downstream matcher via a ready/ack handshake.
- Sits between the video line buffer / GCBP line generator and the sub-image BRAMs.

Parameters:
- BRAM_DATA_WIDTH, 128, GCBP line width (one BRAM word).
- C_VERT_START, 176, first active line index (0-based) of the sub-image window.
- C_SUBIMAGE_HEIGHT, 128, rows per sub-image; power of 2.
- C_LINE_CNT_BITS, 10, line counter width.
- C_ROW_BITS, 7, log2(C_SUBIMAGE_HEIGHT).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  arms capture; sampled only in S_IDLE
- i_new_frame  in  1  1-cycle pulse at frame start
- i_new_line  in  1  1-cycle pulse at each active line start
- o_gen_new_line  out  1  gated new-line strobe to the line generator
- i_gcbp_line  in  BRAM_DATA_WIDTH  line data from the generator
- i_gcbp_line_valid  in  1  line data valid
- i_hori_subimage_cnt  in  2  sub-image index of i_gcbp_line
- o_bram_we  out  1  BRAM write enable
- o_bram_addr  out  1+2+C_ROW_BITS  {bank, subimage, row}
- o_bram_din  out  BRAM_DATA_WIDTH  BRAM write data
- o_frame_ready  out  1  completed frame available in o_rd_bank
- o_rd_bank  out  1  bank the matcher reads
- i_frame_ack  in  1  1-cycle pulse; matcher has finished with o_rd_bank

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset. On reset:
  - state = S_IDLE, r_wr_bank = 0, o_rd_bank = 1, o_frame_ready = 0
  - o_bram_we = 0, o_bram_addr = 0, o_bram_din = 0
  - line counter = 0, row = 0
  - Reset mid-frame discards all progress.
- Line counter: cleared on i_new_frame. Increments on each i_new_line. Saturates at 2^C_LINE_CNT_BITS-1. On each i_new_line, the pre-increment value L is the current line index.
- Window: L in [C_VERT_START, C_VERT_START+C_SUBIMAGE_HEIGHT-1]. On a window hit, row latches L-C_VERT_START (C_ROW_BITS bits).
- FSM (3 states):
  - S_IDLE: when i_new_frame=1 and i_enable=1, go to S_CAPTURE (line counter cleared the same edge).
  - S_CAPTURE:
    - o_gen_new_line = i_new_line AND window hit (combinational, same cycle). Outside S_CAPTURE, o_gen_new_line = 0.
    - Each i_gcbp_line_valid after the first gated line registers a write at the next edge: o_bram_we=1 for 1 cycle, o_bram_addr={r_wr_bank, i_hori_subimage_cnt, row}, o_bram_din=i_gcbp_line.
    - i_gcbp_line_valid before any gated line of the frame is ignored.
    - The write with subimage=3 and row=C_SUBIMAGE_HEIGHT-1 moves the FSM to S_DONE on the same edge.
    - i_new_frame in S_CAPTURE aborts the frame: no swap, line counter cleared, stay in S_CAPTURE.
  - S_DONE (1 cycle), then always to S_IDLE:
    - If o_frame_ready=0, or i_frame_ack=1 this cycle: swap. o_rd_bank <= r_wr_bank, r_wr_bank <= ~r_wr_bank, o_frame_ready <= 1.
    - Otherwise: drop. No swap; the next frame overwrites the same bank.
- Latency: o_frame_ready rises 2 cycles after the final i_gcbp_line_valid.
- Ack: i_frame_ack while o_frame_ready=1 clears it next edge, except when it coincides with a swap in S_DONE; then o_frame_ready stays 1 with the new bank. Ack while o_frame_ready=0 is ignored.
- Invariant: r_wr_bank != o_rd_bank always.
- BRAM writes occur only in S_CAPTURE.

Optional Feature:
- Macro: GCBP_FRAME_DROP_CNT_EN.
- Defined: adds output o_drop_cnt, 8 bits, reset 0, saturating at 255. Increments once per dropped frame in S_DONE and once per abort in S_CAPTURE.
- Undefined: port and counter absent; drop and abort behaviour unchanged.

Test Plan:
- Reset, i_enable=1, full frame of 480 lines with 4 valids per window line -> 512 writes. Addresses 0x000..0x1FF with bank bit=0. o_gen_new_line pulses only on lines 176..303. o_frame_ready=1 and o_rd_bank=0 two cycles after the last valid.
- Second frame, no ack -> writes to bank 0 again, o_frame_ready stays 1, o_rd_bank=0, o_drop_cnt=1 (feature on).
- i_frame_ack in the exact S_DONE cycle of a complete frame -> swap occurs, o_frame_ready remains 1, o_rd_bank toggles.
- i_new_frame after row 50 -> no swap, writes restart at row 0 of the same bank, o_drop_cnt+1.
- i_reset asserted mid-capture (row 64) -> next cycle: o_bram_we=0, o_frame_ready=0, o_rd_bank=1, state S_IDLE. A subsequent frame writes bank 0.
- i_enable=0 at i_new_frame -> no o_gen_new_line and no writes for that whole frame.

Source files
------------

// File: rtl/gcbp_frame_ctrl.sv
// gcbp_frame_ctrl: frame-level sequencer for the GCBP line generator.
// Gates new-line strobes to the vertical sub-image window, writes generated
// lines into a ping-pong sub-image BRAM and hands completed banks to the
// matcher with a ready/ack handshake.
// Optional feature: define GCBP_FRAME_DROP_CNT_EN to add o_drop_cnt, a
// saturating count of dropped and aborted frames.
module gcbp_frame_ctrl #(
  parameter int BRAM_DATA_WIDTH   = 128,
  parameter int C_VERT_START      = 176,
  parameter int C_SUBIMAGE_HEIGHT = 128,
  parameter int C_LINE_CNT_BITS   = 10,
  parameter int C_ROW_BITS        = 7
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_new_frame,
  input  logic                       i_new_line,
  output logic                       o_gen_new_line,
  input  logic [BRAM_DATA_WIDTH-1:0] i_gcbp_line,
  input  logic                       i_gcbp_line_valid,
  input  logic [1:0]                 i_hori_subimage_cnt,
  output logic                       o_bram_we,
  output logic [C_ROW_BITS+2:0]      o_bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0] o_bram_din,
  output logic                       o_frame_ready,
  output logic                       o_rd_bank,
  input  logic                       i_frame_ack
`ifdef GCBP_FRAME_DROP_CNT_EN
  ,output logic [7:0]                o_drop_cnt
`endif
);

  localparam logic [C_LINE_CNT_BITS-1:0] VSTART = C_LINE_CNT_BITS'(C_VERT_START);
  localparam logic [C_LINE_CNT_BITS-1:0] VEND   =
    C_LINE_CNT_BITS'(C_VERT_START + C_SUBIMAGE_HEIGHT - 1);
  localparam logic [C_ROW_BITS-1:0]      ROW_LAST = C_ROW_BITS'(C_SUBIMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t                     state;
  logic                       r_wr_bank;
  logic [C_LINE_CNT_BITS-1:0] line_cnt;
  logic [C_ROW_BITS-1:0]      row;
  logic                       line_seen;  // a gated line has occurred this frame
  logic                       win_hit;
  logic                       wr_fire;
  logic                       last_wr;
  logic                       swap;

  // window test uses the pre-increment line index
  assign win_hit        = i_new_line && (line_cnt >= VSTART) && (line_cnt <= VEND);
  assign o_gen_new_line = (state == S_CAPTURE) && win_hit;
  // abort wins over a coincident line write
  assign wr_fire  = (state == S_CAPTURE) && !i_new_frame && i_gcbp_line_valid && line_seen;
  assign last_wr  = wr_fire && (i_hori_subimage_cnt == 2'd3) && (row == ROW_LAST);
  assign swap     = (state == S_DONE) && (!o_frame_ready || i_frame_ack);

  // line counter: cleared per frame, saturates instead of wrapping
  always_ff @(posedge i_clk) begin
    if (i_reset || i_new_frame)
      line_cnt <= '0;
    else if (i_new_line && line_cnt != '1)
      line_cnt <= line_cnt + 1'b1;
  end

  // frame FSM, BRAM write port and bank handshake
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      r_wr_bank     <= 1'b0;
      o_rd_bank     <= 1'b1;
      o_frame_ready <= 1'b0;
      o_bram_we     <= 1'b0;
      o_bram_addr   <= '0;
      o_bram_din    <= '0;
      row           <= '0;
      line_seen     <= 1'b0;
    end else begin
      o_bram_we <= 1'b0;
      if (i_frame_ack && o_frame_ready && !swap)
        o_frame_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_new_frame && i_enable) begin
            state     <= S_CAPTURE;
            line_seen <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (i_new_frame) begin
            line_seen <= 1'b0;
          end else begin
            if (o_gen_new_line) begin
              line_seen <= 1'b1;
              row       <= C_ROW_BITS'(line_cnt - VSTART);
            end
            if (wr_fire) begin
              o_bram_we   <= 1'b1;
              o_bram_addr <= {r_wr_bank, i_hori_subimage_cnt, row};
              o_bram_din  <= i_gcbp_line;
            end
            if (last_wr)
              state <= S_DONE;
          end
        end
        S_DONE: begin
          if (swap) begin
            o_rd_bank     <= r_wr_bank;
            r_wr_bank     <= ~r_wr_bank;
            o_frame_ready <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GCBP_FRAME_DROP_CNT_EN
  logic drop_evt;
  assign drop_evt = ((state == S_CAPTURE) && i_new_frame) ||
                    ((state == S_DONE) && !swap);

  // saturating count of frames that never reached the matcher
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_drop_cnt <= '0;
    else if (drop_evt && o_drop_cnt != 8'hFF)
      o_drop_cnt <= o_drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_gcbp_frame_ctrl.sv
// Bench for gcbp_frame_ctrl: directed frame sequence with random data and
// timing gaps, checked against a frame-level reference model.
module tb_gcbp_frame_ctrl;

  logic         i_clk = 1'b0;
  logic         i_reset, i_enable, i_new_frame, i_new_line;
  logic         o_gen_new_line;
  logic [127:0] i_gcbp_line;
  logic         i_gcbp_line_valid;
  logic [1:0]   i_hori_subimage_cnt;
  logic         o_bram_we;
  logic [9:0]   o_bram_addr;
  logic [127:0] o_bram_din;
  logic         o_frame_ready, o_rd_bank, i_frame_ack;
`ifdef GCBP_FRAME_DROP_CNT_EN
  logic [7:0]   o_drop_cnt;
`endif

  always #5 i_clk = ~i_clk;

  gcbp_frame_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_new_frame(i_new_frame), .i_new_line(i_new_line),
    .o_gen_new_line(o_gen_new_line), .i_gcbp_line(i_gcbp_line),
    .i_gcbp_line_valid(i_gcbp_line_valid), .i_hori_subimage_cnt(i_hori_subimage_cnt),
    .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr), .o_bram_din(o_bram_din),
    .o_frame_ready(o_frame_ready), .o_rd_bank(o_rd_bank), .i_frame_ack(i_frame_ack)
`ifdef GCBP_FRAME_DROP_CNT_EN
    , .o_drop_cnt(o_drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model: frame capture state, banks, handshake, drop count
  bit m_cap, m_seen, m_wr, m_rd, m_ready;
  int m_row, m_drops;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_reset();
    m_cap = 0; m_seen = 0; m_wr = 0; m_rd = 1; m_ready = 0; m_row = 0; m_drops = 0;
  endtask

  task automatic chk_drops(input string tag);
`ifdef GCBP_FRAME_DROP_CNT_EN
    chk(tag, o_drop_cnt, m_drops);
`endif
  endtask

  task automatic count_drop();
    if (m_drops < 255) m_drops++;
  endtask

  task automatic start_frame(input bit en);
    i_enable = en; i_new_frame = 1; tick(); i_new_frame = 0;
    if (m_cap) begin count_drop(); m_seen = 0; end
    else if (en) begin m_cap = 1; m_seen = 0; end
    chk("we_newframe", o_bram_we, 0);
    chk_drops("drops_newframe");
  endtask

  // cycle after the last write: bank handed over or frame dropped
  task automatic done_cycle(input bit ack);
    i_frame_ack = ack; tick(); i_frame_ack = 0;
    if (!m_ready || ack) begin m_rd = m_wr; m_wr = !m_wr; m_ready = 1; end
    else count_drop();
    m_cap = 0;
    chk("ready_done", o_frame_ready, m_ready);
    chk("rdbank_done", o_rd_bank, m_rd);
    chk("we_done", o_bram_we, 0);
    chk_drops("drops_done");
  endtask

  task automatic send_line(input int l, input bit valids, input bit ack_done);
    int  ls;
    bit  hit;
    ls  = (l > 1023) ? 1023 : l;
    hit = (ls >= 176) && (ls <= 303);
    i_new_line = 1; #1;
    chk("gen_new_line", o_gen_new_line, m_cap && hit);
    tick(); i_new_line = 0;
    if (m_cap && hit) begin m_seen = 1; m_row = ls - 176; end
    chk("we_line", o_bram_we, 0);
    if (hit && valids) begin
      for (int s = 0; s < 4; s++) begin
        logic [127:0] d;
        logic [1:0]   sub;
        logic [6:0]   r;
        bit           exp_we;
        repeat ($urandom_range(0, 1)) tick();
        d   = {$urandom, $urandom, $urandom, $urandom};
        sub = s[1:0];
        r   = m_row[6:0];
        i_gcbp_line = d; i_gcbp_line_valid = 1; i_hori_subimage_cnt = sub;
        exp_we = m_cap && m_seen;
        tick(); i_gcbp_line_valid = 0;
        chk("we", o_bram_we, exp_we);
        if (exp_we) begin
          chk("addr", o_bram_addr, {m_wr, sub, r});
          chk("din", o_bram_din, d);
          if (s == 3 && m_row == 127) done_cycle(ack_done);
        end
      end
    end
  endtask

  task automatic frame(input bit en, input int nlines, input int stop_row,
                       input bit valids, input bit ack_done);
    start_frame(en);
    for (int l = 0; l < nlines; l++) begin
      send_line(l, valids, ack_done);
      if (stop_row >= 0 && l - 176 == stop_row) return;
      repeat ($urandom_range(0, 1)) tick();
    end
  endtask

  task automatic ack_pulse();
    i_frame_ack = 1; tick(); i_frame_ack = 0;
    if (m_ready) m_ready = 0;
    chk("ready_ack", o_frame_ready, m_ready);
    chk("rdbank_ack", o_rd_bank, m_rd);
  endtask

  initial begin
    i_reset = 1; i_enable = 0; i_new_frame = 0; i_new_line = 0;
    i_gcbp_line = '0; i_gcbp_line_valid = 0; i_hori_subimage_cnt = 0; i_frame_ack = 0;
    tick(); tick();
    i_reset = 0;
    model_reset();
    chk("rst_we", o_bram_we, 0);
    chk("rst_addr", o_bram_addr, 0);
    chk("rst_din", o_bram_din, 0);
    chk("rst_ready", o_frame_ready, 0);
    chk("rst_rdbank", o_rd_bank, 1);
    chk("rst_gen", o_gen_new_line, 0);
    chk_drops("rst_drops");

    frame(1, 480, -1, 1, 0);            // first frame: bank 0 handed over
    frame(1, 480, -1, 1, 0);            // no ack: dropped
    frame(1, 480, -1, 1, 1);            // ack in the handover cycle: swap
    frame(1, 480, 50, 1, 0);            // abandoned after row 50
    frame(1, 480, -1, 1, 0);            // new frame aborts it, restarts row 0
    ack_pulse();
    ack_pulse();                        // ack while not ready is ignored

    frame(1, 480, 64, 1, 0);            // reset lands mid-capture
    i_reset = 1; tick(); i_reset = 0;
    model_reset();
    chk("midrst_we", o_bram_we, 0);
    chk("midrst_ready", o_frame_ready, 0);
    chk("midrst_rdbank", o_rd_bank, 1);
    chk_drops("midrst_drops");
    send_line(200, 1, 0);               // idle: no strobe, no writes
    frame(1, 480, -1, 1, 0);            // writes bank 0 again

    frame(0, 480, -1, 1, 0);            // disabled frame: nothing happens
    frame(1, 1400, -1, 0, 0);           // line counter must saturate, not wrap

    for (int k = 0; k < 3; k++) begin
      bit en, ack;
      en  = ($urandom_range(0, 3) != 0);
      ack = $urandom_range(0, 1);
      frame(en, 480, -1, 1, ack);
      if ($urandom_range(0, 1)) ack_pulse();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
